// File: rtl/mem_responder.sv
// Memory-side responder: MAR, MDR and a word-addressed RAM with fixed read/write latency.
// Optional write protection of addresses 0..WP_LIMIT-1 is enabled by defining MEM_WP_EN.
module mem_responder #(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 512,
   parameter int RD_LAT   = 2,
   parameter int WR_LAT   = 2,
   parameter int WP_LIMIT = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              Read,
   input  logic              Write,
   input  logic              MARin,
   input  logic              MDRin,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] mdr_q,
   output logic [ADDR_W-1:0] mar_q,
   output logic              busy,
   output logic              ready,
   output logic              err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              read_d_r;
   logic              write_d_r;
   logic [ADDR_W-1:0] mar_r;
   logic [DATA_W-1:0] mdr_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;
   logic              busy_r;
   logic              ready_r;
   logic              err_r;
   logic [DATA_W-1:0] mem_r [0:DEPTH-1];

   logic              rd_start_s;
   logic              wr_start_s;
   logic [ADDR_W-1:0] req_addr_s;
   logic [DATA_W-1:0] req_data_s;
   logic              last_s;
   logic              in_range_s;
   logic              wp_s;
   logic              violation_s;
   logic              commit_s;
   logic [DATA_W-1:0] rd_word_s;

   assign rd_start_s  = Read & ~read_d_r;
   assign wr_start_s  = Write & ~write_d_r;
   assign req_addr_s  = MARin ? bus_in[ADDR_W-1:0] : mar_r;
   assign req_data_s  = MDRin ? bus_in : mdr_r;
   assign last_s      = (cnt_r == CNT_W'(1));
   assign in_range_s  = (int'(addr_r) < DEPTH);
   assign violation_s = MARin | MDRin | rd_start_s | wr_start_s;
   assign rd_word_s   = in_range_s ? mem_r[addr_r[IDX_W-1:0]] : {DATA_W{1'b0}};

`ifdef MEM_WP_EN
   assign wp_s = (int'(addr_r) < WP_LIMIT);
`else
   // Protection is compiled out; WP_LIMIT has no effect on this build.
   assign wp_s = 1'b0 & (WP_LIMIT > DEPTH);
`endif

   assign commit_s = (state_r == ST_WR) & last_s & in_range_s & ~wp_s & ~clr;

   // Control FSM, MAR/MDR registers and registered status pulses.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         read_d_r  <= 1'b0;
         write_d_r <= 1'b0;
         mar_r     <= {ADDR_W{1'b0}};
         mdr_r     <= {DATA_W{1'b0}};
         addr_r    <= {ADDR_W{1'b0}};
         data_r    <= {DATA_W{1'b0}};
         busy_r    <= 1'b0;
         ready_r   <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         read_d_r  <= Read;
         write_d_r <= Write;
         ready_r   <= 1'b0;
         err_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (MARin) mar_r <= bus_in[ADDR_W-1:0];
               if (MDRin && !rd_start_s) mdr_r <= bus_in;
               if (rd_start_s && wr_start_s) begin
                  err_r <= 1'b1;
               end else if (rd_start_s) begin
                  addr_r  <= req_addr_s;
                  cnt_r   <= CNT_W'(RD_LAT);
                  state_r <= ST_RD;
                  busy_r  <= 1'b1;
               end else if (wr_start_s) begin
                  addr_r  <= req_addr_s;
                  data_r  <= req_data_s;
                  cnt_r   <= CNT_W'(WR_LAT);
                  state_r <= ST_WR;
                  busy_r  <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_RD, ST_WR: begin
               // Strobes during an access are dropped; only the fault is reported.
               if (violation_s) err_r <= 1'b1;
               cnt_r <= cnt_r - CNT_W'(1);
               if (last_s) begin
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
                  if (state_r == ST_RD) begin
                     mdr_r <= rd_word_s;
                  end else if (wp_s) begin
                     err_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= {CNT_W{1'b0}};
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // RAM write port; contents survive clr.
   always_ff @(posedge clk) begin
      if (commit_s) mem_r[addr_r[IDX_W-1:0]] <= data_r;
   end

   assign mdr_q = mdr_r;
   assign mar_q = mar_r;
   assign busy  = busy_r;
   assign ready = ready_r;
   assign err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench for mem_responder (DEPTH=500 so addresses 500..511 are out of range).
// Build with MEM_WP_EN defined to exercise the write-protection expectations.
module tb_mem_responder;

   logic        clk;
   logic        clr;
   logic        Read;
   logic        Write;
   logic        MARin;
   logic        MDRin;
   logic [31:0] bus_in;
   logic [31:0] mdr_q;
   logic [8:0]  mar_q;
   logic        busy;
   logic        ready;
   logic        err;

   int checks;
   int errors;

   mem_responder #(
      .ADDR_W(9), .DATA_W(32), .DEPTH(500), .RD_LAT(2), .WR_LAT(2), .WP_LIMIT(4)
   ) dut (
      .clk(clk), .clr(clr), .Read(Read), .Write(Write), .MARin(MARin), .MDRin(MDRin),
      .bus_in(bus_in), .mdr_q(mdr_q), .mar_q(mar_q), .busy(busy), .ready(ready), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctl;   // {Read, Write, MARin, MDRin}
      logic [31:0] bus;
      logic [31:0] mdr;
      logic [8:0]  mar;
      logic [2:0]  st;    // {busy, ready, err}
   } vec_t;

   vec_t tbl [46];

   function automatic vec_t v(input logic [3:0] ctl, input logic [31:0] bus,
                              input logic [31:0] mdr, input logic [8:0] mar, input logic [2:0] st);
      vec_t r;
      r.ctl = ctl; r.bus = bus; r.mdr = mdr; r.mar = mar; r.st = st;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ctl, input logic [31:0] bus);
      {Read, Write, MARin, MDRin} = ctl;
      bus_in = bus;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string name, input logic [31:0] mdr, input logic [8:0] mar,
                          input logic [2:0] st);
      chk({name, ".mdr"}, mdr_q, mdr);
      chk({name, ".mar"}, {23'd0, mar_q}, {23'd0, mar});
      chk({name, ".st"}, {29'd0, busy, ready, err}, {29'd0, st});
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clr = 1'b1;
      drive(4'b0000, 32'h0);
      tick();
      tick();
      clr = 1'b0;
      chk_all("reset", 32'h0, 9'h000, 3'b000);

      // write 0xDEADBEEF to 5, then read it back; Read held to prove single access
      tbl[0]  = v(4'b0010, 32'h0000_0005, 32'h0000_0000, 9'h005, 3'b000);
      tbl[1]  = v(4'b0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 9'h005, 3'b000);
      tbl[2]  = v(4'b0100, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b100);
      tbl[3]  = v(4'b0100, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b100);
      tbl[4]  = v(4'b0000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b010);
      tbl[5]  = v(4'b0000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b000);
      tbl[6]  = v(4'b0001, 32'h0,         32'h0000_0000, 9'h005, 3'b000);
      tbl[7]  = v(4'b1000, 32'h0,         32'h0000_0000, 9'h005, 3'b100);
      tbl[8]  = v(4'b1000, 32'h0,         32'h0000_0000, 9'h005, 3'b100);
      tbl[9]  = v(4'b1000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b010);
      tbl[10] = v(4'b1000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b000);
      tbl[11] = v(4'b1000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b000);
      tbl[12] = v(4'b0001, 32'h0,         32'h0000_0000, 9'h005, 3'b000);
      tbl[13] = v(4'b1000, 32'h0,         32'h0000_0000, 9'h005, 3'b100);
      tbl[14] = v(4'b1000, 32'h0,         32'h0000_0000, 9'h005, 3'b100);
      tbl[15] = v(4'b1000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b010);
      tbl[16] = v(4'b0000, 32'h0,         32'hDEAD_BEEF, 9'h005, 3'b000);
      // write 0x12345678 to 0x10, read back, then back-to-back write on the ready cycle
      tbl[17] = v(4'b0010, 32'h0000_0010, 32'hDEAD_BEEF, 9'h010, 3'b000);
      tbl[18] = v(4'b0001, 32'h1234_5678, 32'h1234_5678, 9'h010, 3'b000);
      tbl[19] = v(4'b0100, 32'h0,         32'h1234_5678, 9'h010, 3'b100);
      tbl[20] = v(4'b0100, 32'h0,         32'h1234_5678, 9'h010, 3'b100);
      tbl[21] = v(4'b0000, 32'h0,         32'h1234_5678, 9'h010, 3'b010);
      tbl[22] = v(4'b0001, 32'h0,         32'h0000_0000, 9'h010, 3'b000);
      tbl[23] = v(4'b1000, 32'h0,         32'h0000_0000, 9'h010, 3'b100);
      tbl[24] = v(4'b1000, 32'h0,         32'h0000_0000, 9'h010, 3'b100);
      tbl[25] = v(4'b0000, 32'h0,         32'h1234_5678, 9'h010, 3'b010);
      tbl[26] = v(4'b0111, 32'hCAFE_0011, 32'hCAFE_0011, 9'h011, 3'b100);
      tbl[27] = v(4'b0100, 32'h0,         32'hCAFE_0011, 9'h011, 3'b100);
      tbl[28] = v(4'b0000, 32'h0,         32'hCAFE_0011, 9'h011, 3'b010);
      tbl[29] = v(4'b0001, 32'h0,         32'h0000_0000, 9'h011, 3'b000);
      tbl[30] = v(4'b1000, 32'h0,         32'h0000_0000, 9'h011, 3'b100);
      tbl[31] = v(4'b1001, 32'h0000_AAAA, 32'h0000_0000, 9'h011, 3'b101);
      tbl[32] = v(4'b0000, 32'h0,         32'hCAFE_0011, 9'h011, 3'b010);
      // simultaneous Read/Write rise
      tbl[33] = v(4'b1100, 32'h0,         32'hCAFE_0011, 9'h011, 3'b001);
      tbl[34] = v(4'b0000, 32'h0,         32'hCAFE_0011, 9'h011, 3'b000);
      // out-of-range address 500: write ignored, read returns 0
      tbl[35] = v(4'b0010, 32'h0000_01F4, 32'hCAFE_0011, 9'h1F4, 3'b000);
      tbl[36] = v(4'b0001, 32'h0000_0077, 32'h0000_0077, 9'h1F4, 3'b000);
      tbl[37] = v(4'b0100, 32'h0,         32'h0000_0077, 9'h1F4, 3'b100);
      tbl[38] = v(4'b0000, 32'h0,         32'h0000_0077, 9'h1F4, 3'b100);
      tbl[39] = v(4'b0000, 32'h0,         32'h0000_0077, 9'h1F4, 3'b010);
      tbl[40] = v(4'b1000, 32'h0,         32'h0000_0077, 9'h1F4, 3'b100);
      tbl[41] = v(4'b0000, 32'h0,         32'h0000_0077, 9'h1F4, 3'b100);
      tbl[42] = v(4'b0000, 32'h0,         32'h0000_0000, 9'h1F4, 3'b010);
      // MARin while busy is ignored
      tbl[43] = v(4'b1000, 32'h0,         32'h0000_0000, 9'h1F4, 3'b100);
      tbl[44] = v(4'b0010, 32'h0000_0005, 32'h0000_0000, 9'h1F4, 3'b101);
      tbl[45] = v(4'b0000, 32'h0,         32'h0000_0000, 9'h1F4, 3'b010);

      for (int i = 0; i < 46; i++) begin
         drive(tbl[i].ctl, tbl[i].bus);
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].mdr, tbl[i].mar, tbl[i].st);
      end

      // clr in the middle of a write to address 5: abort, old word survives
      drive(4'b0010, 32'h0000_0005); tick();
      drive(4'b0001, 32'h1111_1111); tick();
      drive(4'b0100, 32'h0);         tick();
      chk("clr_pre.busy", {31'd0, busy}, 32'd1);
      clr = 1'b1;                    tick();
      clr = 1'b0;
      chk_all("clr_abort", 32'h0, 9'h000, 3'b000);
      drive(4'b0000, 32'h0);         tick();
      tick();
      chk_all("clr_quiet", 32'h0, 9'h000, 3'b000);
      drive(4'b0010, 32'h0000_0005); tick();
      drive(4'b1000, 32'h0);         tick();
      drive(4'b0000, 32'h0);         tick();
      tick();
      chk_all("clr_keep", 32'hDEAD_BEEF, 9'h005, 3'b010);

      // write 0x55 to address 2 (protected when MEM_WP_EN is defined)
      drive(4'b0010, 32'h0000_0002); tick();
      drive(4'b0001, 32'h0000_0055); tick();
      drive(4'b0100, 32'h0);         tick();
      drive(4'b0000, 32'h0);         tick();
      tick();
`ifdef MEM_WP_EN
      chk_all("wp2_done", 32'h55, 9'h002, 3'b011);
`else
      chk_all("wp2_done", 32'h55, 9'h002, 3'b010);
`endif
      drive(4'b0001, 32'h0);         tick();
      drive(4'b1000, 32'h0);         tick();
      drive(4'b0000, 32'h0);         tick();
      tick();
`ifdef MEM_WP_EN
      chk("wp2_blocked", {31'd0, (mdr_q != 32'h55)}, 32'd1);
`else
      chk("wp2_read", mdr_q, 32'h55);
`endif

      // write 0x66 to address 4 (just above the protected range)
      drive(4'b0010, 32'h0000_0004); tick();
      drive(4'b0001, 32'h0000_0066); tick();
      drive(4'b0100, 32'h0);         tick();
      drive(4'b0000, 32'h0);         tick();
      tick();
      chk_all("wp4_done", 32'h66, 9'h004, 3'b010);
      drive(4'b0001, 32'h0);         tick();
      drive(4'b1000, 32'h0);         tick();
      drive(4'b0000, 32'h0);         tick();
      tick();
      chk_all("wp4_read", 32'h66, 9'h004, 3'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
